puf_resp_sampler: RTL and testbench
===================================

# puf_resp_sampler

- Sequential controller at the response end of the arbiter-PUF delay chain.
- Accepts a challenge over a valid/ready handshake and drives it onto the chain's per-stage select lines.
- Fires the race `REPS` times, samples the arbiter latch output through a synchronizer, and majority-votes the samples.
- Returns one response bit plus a stability count over a second valid/ready handshake. It sits between the AXI register front-end and the chain of switch stages.

## Interface
Parameters:
- `STAGES`, 64: number of switch stages; challenge width.
- `REPS`, 15: races per challenge; must be odd, ≥1.
- `SETTLE_CYC`, 8: cycles the challenge is held with launch low before the first race.
- `EVAL_CYC`, 16: cycles launch is held high per race; must be ≥3.
- `RESET_CYC`, 8: cycles launch is held low between races.

Ports:
- `s00_axi_aclk`, in, 1: sole clock.
- `s00_axi_aresetn`, in, 1: synchronous, active-low reset.
- `chal_valid`, in, 1: challenge offered.
- `chal_ready`, out, 1: block can accept a challenge.
- `chal_data`, in, `STAGES`: challenge bits.
- `puf_chal`, out, `STAGES`: registered select lines to the stages.
- `puf_launch`, out, 1: race edge into both chain inputs.
- `puf_arb_q`, in, 1: arbiter latch output; asynchronous to the clock.
- `resp_valid`, out, 1: response available.
- `resp_ready`, in, 1: consumer takes the response.
- `resp_bit`, out, 1: majority response.
- `resp_ones`, out, `$clog2(REPS+1)`: count of samples equal to 1.
- `resp_stable`, out, 1: `resp_ones` is 0 or `REPS`.
- `busy`, out, 1: state is not `IDLE`.

## Operation
FSM states: `IDLE`, `SETTLE`, `LAUNCH`, `RECOVER`, `DONE`.
- `IDLE`: `chal_ready`=1. On `chal_valid`&`chal_ready`: latch `chal_data` into `puf_chal`, clear the ones and rep counters, go to `SETTLE`.
- `SETTLE`: `puf_launch`=0 for `SETTLE_CYC` cycles, then go to `LAUNCH`.
- `LAUNCH`: `puf_launch`=1 for `EVAL_CYC` cycles.
  - On the last cycle, add the synchronized arbiter output to the ones count.
  - Then go to `RECOVER`.
- `RECOVER`: `puf_launch`=0 for `RESET_CYC` cycles. Then go to `LAUNCH` if fewer than `REPS` races are done, else go to `DONE`.
- `DONE`: `resp_valid`=1.
  - `resp_bit` = (ones > `REPS`/2).
  - `resp_stable` = (ones==0 or ones==`REPS`).
  - Hold all outputs until `resp_ready`, then go to `IDLE`.

Rules:
- `puf_chal` changes only on challenge acceptance and is held through `DONE`.
- `chal_ready` is 0 outside `IDLE`, so a new challenge cannot overlap a response. There is a mandatory one-cycle bubble between `resp` and `chal` handshakes.
- `chal_valid` while busy is ignored, not queued.
- The ones counter saturates at `REPS`; this cannot occur by construction, but the saturation is asserted.
- `puf_arb_q` passes through a 2-FF synchronizer before use. Only the synchronized value is sampled.

## Timing
- Reset values:
  - State `IDLE`; `chal_ready`=1.
  - `puf_chal`=0, `puf_launch`=0.
  - `resp_valid`=0, `resp_bit`=0, `resp_ones`=0, `resp_stable`=0, `busy`=0.
  - Synchronizer flops 0.
- Reset asserted mid-operation returns to these values on the next edge. `puf_launch` drops in that same cycle. No response is emitted for the aborted challenge.
- All outputs are registered.
- Latency: `resp_valid` rises exactly `SETTLE_CYC + REPS*(EVAL_CYC+RESET_CYC)` cycles after the acceptance edge.
- A race's sample uses arbiter data settled at least `EVAL_CYC-2` cycles after the launch edge.
- `resp_valid` with `resp_ready` already high completes in one cycle. `chal_ready` returns the following cycle.

## Structure
- Shared package `puf_pkg` holds:
  - the FSM state encoding;
  - `localparam` helpers for counter widths (`$clog2` of `REPS+1`, and of the max of the cycle parameters);
  - default parameter constants shared with the AXI wrapper.
- One sub-module, `puf_sync2`: a 2-flop synchronizer with `ASYNC_REG` and `dont_touch` attributes and a synchronous active-low clear.

## Test plan
Use `STAGES`=8, `REPS`=5, `SETTLE_CYC`=4, `EVAL_CYC`=6, `RESET_CYC`=3 unless noted.
1. Arbiter model forced to 1, challenge 8'hA5 → `puf_chal`=8'hA5 one cycle after acceptance; `resp_valid` 49 cycles after acceptance; `resp_bit`=1, `resp_ones`=5, `resp_stable`=1.
2. Arbiter samples 1,0,1,0,1 per race → `resp_bit`=1, `resp_ones`=3, `resp_stable`=0. With samples 0,0,1,0,1 → `resp_bit`=0, `resp_ones`=2.
3. `resp_ready` held low 20 cycles in `DONE` while `chal_valid`=1 with 8'h3C → outputs stable, `chal_ready`=0, `puf_chal` unchanged. After `resp_ready`, 8'h3C is accepted one cycle later.
4. `s00_axi_aresetn` low during the 3rd `LAUNCH` → next edge: `puf_launch`=0, `busy`=0, all outputs at reset values. No `resp_valid` for that challenge.
5. Count `puf_launch` pulses per challenge → exactly 5 pulses, each 6 cycles high, separated by 3 low cycles. The first pulse starts 4 cycles after acceptance.
6. `REPS`=1, arbiter toggling asynchronously (phase-shifted stimulus) → exactly one response; `resp_stable`=1; `resp_ones` ∈ {0,1}.

Source files
------------

// File: rtl/puf_pkg.sv
// rtl/puf_pkg.sv - shared FSM encoding, width helpers and defaults for the PUF response sampler
// Contents:
//   state_t     : sampler FSM states
//   ones_width  : width of a 0..reps counter
//   cyc_width   : width of a phase counter covering the longest of three phase lengths
//   DEF_*       : default parameter values shared with the register front-end wrapper
package puf_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SETTLE  = 3'd1,
      ST_LAUNCH  = 3'd2,
      ST_RECOVER = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   localparam int DEF_STAGES     = 64;
   localparam int DEF_REPS       = 15;
   localparam int DEF_SETTLE_CYC = 8;
   localparam int DEF_EVAL_CYC   = 16;
   localparam int DEF_RESET_CYC  = 8;

   function automatic int ones_width(input int reps);
      return $clog2(reps + 1);
   endfunction

   // Phase counters run 0..len-1, so clog2 of the longest length is enough.
   function automatic int cyc_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

   localparam int DEF_ONES_W = ones_width(DEF_REPS);
   localparam int DEF_CYC_W  = cyc_width(DEF_SETTLE_CYC, DEF_EVAL_CYC, DEF_RESET_CYC);

endpackage

// File: rtl/puf_resp_sampler_if.sv
// rtl/puf_resp_sampler_if.sv - challenge/response handshake bundle of the PUF response sampler
// Signals:
//   chal_valid/chal_ready/chal_data           : challenge handshake (master -> sampler)
//   resp_valid/resp_ready/resp_bit/resp_ones/
//   resp_stable                               : response handshake (sampler -> master)
// Modports: master = register front-end side, slave = sampler side.
interface puf_resp_sampler_if
   import puf_pkg::*;
#(
   parameter int STAGES = DEF_STAGES,
   parameter int REPS   = DEF_REPS
) ();
   localparam int ONES_W = ones_width(REPS);

   logic              chal_valid;
   logic              chal_ready;
   logic [STAGES-1:0] chal_data;
   logic              resp_valid;
   logic              resp_ready;
   logic              resp_bit;
   logic [ONES_W-1:0] resp_ones;
   logic              resp_stable;

   modport master (
      output chal_valid, chal_data, resp_ready,
      input  chal_ready, resp_valid, resp_bit, resp_ones, resp_stable
   );

   modport slave (
      input  chal_valid, chal_data, resp_ready,
      output chal_ready, resp_valid, resp_bit, resp_ones, resp_stable
   );
endinterface

// File: rtl/puf_sync2.sv
// rtl/puf_sync2.sv - two-flop synchronizer with synchronous active-low clear
// Ports:
//   clk   : destination clock
//   clr_n : synchronous active-low clear of both flops
//   d     : asynchronous input
//   q     : synchronized output
module puf_sync2 (
   input  logic clk,
   input  logic clr_n,
   input  logic d,
   output logic q
);
   (* ASYNC_REG = "TRUE", dont_touch = "true" *) logic meta_q;
   (* ASYNC_REG = "TRUE", dont_touch = "true" *) logic sync_q;

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;
endmodule

// File: rtl/puf_resp_sampler.sv
// rtl/puf_resp_sampler.sv - arbiter-PUF response sampler: settle, REPS races, majority vote
// Ports:
//   s00_axi_aclk    : sole clock
//   s00_axi_aresetn : synchronous active-low reset
//   host            : challenge/response handshakes (slave side)
//   puf_chal        : registered stage select lines
//   puf_launch      : race edge into the chain
//   puf_arb_q       : asynchronous arbiter latch output
//   busy            : sampler not idle
module puf_resp_sampler
   import puf_pkg::*;
#(
   parameter int STAGES     = DEF_STAGES,
   parameter int REPS       = DEF_REPS,
   parameter int SETTLE_CYC = DEF_SETTLE_CYC,
   parameter int EVAL_CYC   = DEF_EVAL_CYC,
   parameter int RESET_CYC  = DEF_RESET_CYC
) (
   input  logic              s00_axi_aclk,
   input  logic              s00_axi_aresetn,
   puf_resp_sampler_if.slave host,
   output logic [STAGES-1:0] puf_chal,
   output logic              puf_launch,
   input  logic              puf_arb_q,
   output logic              busy
);
   localparam int ONES_W = ones_width(REPS);
   localparam int CYC_W  = cyc_width(SETTLE_CYC, EVAL_CYC, RESET_CYC);

   localparam logic [CYC_W-1:0]  SETTLE_LAST = CYC_W'(SETTLE_CYC - 1);
   localparam logic [CYC_W-1:0]  EVAL_LAST   = CYC_W'(EVAL_CYC - 1);
   localparam logic [CYC_W-1:0]  RESET_LAST  = CYC_W'(RESET_CYC - 1);
   localparam logic [ONES_W-1:0] REPS_N      = ONES_W'(REPS);
   localparam logic [ONES_W-1:0] HALF_N      = ONES_W'(REPS / 2);

   state_t            state_q, state_d;
   logic [CYC_W-1:0]  cnt_q, cnt_d;
   logic [ONES_W-1:0] rep_q, rep_d;
   logic [ONES_W-1:0] ones_q, ones_d;
   logic [STAGES-1:0] chal_q, chal_d;
   logic              launch_q, launch_d;
   logic              chal_ready_q, chal_ready_d;
   logic              busy_q, busy_d;
   logic              resp_valid_q, resp_valid_d;
   logic              resp_bit_q, resp_bit_d;
   logic              resp_stable_q, resp_stable_d;
   logic              sample;
   logic              arb_sync;

   puf_sync2 u_sync (
      .clk   (s00_axi_aclk),
      .clr_n (s00_axi_aresetn),
      .d     (puf_arb_q),
      .q     (arb_sync)
   );

   always_ff @(posedge s00_axi_aclk) begin
      if (!s00_axi_aresetn) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         rep_q         <= '0;
         ones_q        <= '0;
         chal_q        <= '0;
         launch_q      <= 1'b0;
         chal_ready_q  <= 1'b1;
         busy_q        <= 1'b0;
         resp_valid_q  <= 1'b0;
         resp_bit_q    <= 1'b0;
         resp_stable_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         rep_q         <= rep_d;
         ones_q        <= ones_d;
         chal_q        <= chal_d;
         launch_q      <= launch_d;
         chal_ready_q  <= chal_ready_d;
         busy_q        <= busy_d;
         resp_valid_q  <= resp_valid_d;
         resp_bit_q    <= resp_bit_d;
         resp_stable_q <= resp_stable_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      rep_d         = rep_q;
      ones_d        = ones_q;
      chal_d        = chal_q;
      resp_bit_d    = resp_bit_q;
      resp_stable_d = resp_stable_q;
      sample        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (host.chal_valid) begin
               chal_d  = host.chal_data;
               cnt_d   = '0;
               rep_d   = '0;
               ones_d  = '0;
               state_d = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == SETTLE_LAST) begin
               cnt_d   = '0;
               state_d = ST_LAUNCH;
            end else begin
               cnt_d = cnt_q + CYC_W'(1);
            end
         end
         ST_LAUNCH: begin
            if (cnt_q == EVAL_LAST) begin
               sample  = 1'b1;
               cnt_d   = '0;
               rep_d   = rep_q + ONES_W'(1);
               state_d = ST_RECOVER;
            end else begin
               cnt_d = cnt_q + CYC_W'(1);
            end
         end
         ST_RECOVER: begin
            if (cnt_q == RESET_LAST) begin
               cnt_d   = '0;
               state_d = (rep_q == REPS_N) ? ST_DONE : ST_LAUNCH;
            end else begin
               cnt_d = cnt_q + CYC_W'(1);
            end
         end
         ST_DONE: begin
            if (host.resp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Saturating count of ones; the limit is unreachable since exactly REPS samples are taken.
      if (sample && arb_sync && (ones_q != REPS_N)) ones_d = ones_q + ONES_W'(1);

      // Vote is frozen on DONE entry, when the last sample is already in ones_q.
      if ((state_q == ST_RECOVER) && (state_d == ST_DONE)) begin
         resp_bit_d    = (ones_q > HALF_N);
         resp_stable_d = (ones_q == '0) || (ones_q == REPS_N);
      end

      // Outputs are registered copies of the next-state decode so they align with the state.
      launch_d     = (state_d == ST_LAUNCH);
      chal_ready_d = (state_d == ST_IDLE);
      busy_d       = (state_d != ST_IDLE);
      resp_valid_d = (state_d == ST_DONE);
   end

   ones_sat_a: assert property (@(posedge s00_axi_aclk) disable iff (!s00_axi_aresetn)
      !(sample && arb_sync && (ones_q == REPS_N)));

   assign host.chal_ready  = chal_ready_q;
   assign host.resp_valid  = resp_valid_q;
   assign host.resp_bit    = resp_bit_q;
   assign host.resp_ones   = ones_q;
   assign host.resp_stable = resp_stable_q;
   assign puf_chal         = chal_q;
   assign puf_launch       = launch_q;
   assign busy             = busy_q;
endmodule

// File: tb/tb_puf_resp_sampler.sv
// tb/tb_puf_resp_sampler.sv - self-checking bench for puf_resp_sampler
module tb_puf_resp_sampler;
   import puf_pkg::*;

   localparam int ST  = 8;
   localparam int RP  = 5;
   localparam int SC  = 4;
   localparam int EC  = 6;
   localparam int RC  = 3;
   localparam int P   = EC + RC;
   localparam int LAT = SC + RP * P;
   localparam int LAT1 = SC + P;

   logic          clk  = 1'b0;
   logic          rstn = 1'b0;
   logic [ST-1:0] puf_chal;
   logic          puf_launch;
   logic          arb = 1'b0;
   logic          busy;
   logic [ST-1:0] puf_chal1;
   logic          puf_launch1;
   logic          arb1 = 1'b0;
   logic          busy1;

   puf_resp_sampler_if #(.STAGES(ST), .REPS(RP)) bus ();
   puf_resp_sampler_if #(.STAGES(ST), .REPS(1))  bus1 ();

   puf_resp_sampler #(.STAGES(ST), .REPS(RP), .SETTLE_CYC(SC), .EVAL_CYC(EC), .RESET_CYC(RC)) dut (
      .s00_axi_aclk    (clk),
      .s00_axi_aresetn (rstn),
      .host            (bus),
      .puf_chal        (puf_chal),
      .puf_launch      (puf_launch),
      .puf_arb_q       (arb),
      .busy            (busy)
   );

   puf_resp_sampler #(.STAGES(ST), .REPS(1), .SETTLE_CYC(SC), .EVAL_CYC(EC), .RESET_CYC(RC)) dut1 (
      .s00_axi_aclk    (clk),
      .s00_axi_aresetn (rstn),
      .host            (bus1),
      .puf_chal        (puf_chal1),
      .puf_launch      (puf_launch1),
      .puf_arb_q       (arb1),
      .busy            (busy1)
   );

   initial forever #5 clk = ~clk;
   initial forever #7 arb1 = ~arb1;

   int            checks = 0;
   int            errors = 0;
   bit            m_active = 1'b0;
   int            m_t = 0;
   logic [ST-1:0] m_chal = '0;
   logic [RP-1:0] m_pat = '0;
   logic [RP-1:0] pat = '0;
   int            n_pulse = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic int popc(input logic [RP-1:0] p);
      int n = 0;
      for (int i = 0; i < RP; i++) if (p[i]) n++;
      return n;
   endfunction

   // Rising edges of puf_launch, seen from the DUT.
   initial begin : pulse_count
      logic prev = 1'b0;
      forever begin
         @(negedge clk);
         if (puf_launch && !prev) n_pulse++;
         prev = puf_launch;
      end
   end

   // Reference model: time since acceptance decides every output; it also plays the arbiter.
   initial begin : model
      logic exp_launch, exp_valid, just_rst;
      int   ones, r, off;
      forever begin
         @(posedge clk);
         #1;
         just_rst = 1'b0;
         if (!rstn) begin
            m_active = 1'b0;
            m_chal   = '0;
            just_rst = 1'b1;
         end else if (m_active) begin
            if (m_t >= LAT && bus.resp_ready) m_active = 1'b0;
            else m_t++;
         end else if (bus.chal_valid) begin
            m_active = 1'b1;
            m_t      = 0;
            m_chal   = bus.chal_data;
            m_pat    = pat;
         end
         off        = m_t - SC;
         exp_launch = m_active && (m_t >= SC) && (m_t < LAT) && ((off % P) < EC);
         exp_valid  = m_active && (m_t >= LAT);
         chk("chal_ready", 32'(bus.chal_ready), 32'(!m_active));
         chk("busy", 32'(busy), 32'(m_active));
         chk("puf_launch", 32'(puf_launch), 32'(exp_launch));
         chk("resp_valid", 32'(bus.resp_valid), 32'(exp_valid));
         chk("puf_chal", 32'(puf_chal), 32'(m_chal));
         if (exp_valid) begin
            ones = popc(m_pat);
            chk("resp_ones", 32'(bus.resp_ones), 32'(ones));
            chk("resp_bit", 32'(bus.resp_bit), 32'(ones > RP / 2));
            chk("resp_stable", 32'(bus.resp_stable), 32'((ones == 0) || (ones == RP)));
         end else if (just_rst) begin
            chk("rst_resp_ones", 32'(bus.resp_ones), 32'(0));
            chk("rst_resp_bit", 32'(bus.resp_bit), 32'(0));
            chk("rst_resp_stable", 32'(bus.resp_stable), 32'(0));
         end
         // Race value is present only on the cycle whose edge the last LAUNCH sample depends on;
         // any other cycle drives its complement so a mistimed sample shows up.
         if (m_active && (m_t >= SC) && (m_t < LAT)) begin
            r   = off / P;
            arb = ((off % P) == EC - 3) ? m_pat[r] : ~m_pat[r];
         end else if (m_active) begin
            arb = ~m_pat[0];
         end else begin
            arb = 1'($urandom);
         end
      end
   end

   task automatic offer(input logic [ST-1:0] d, input logic [RP-1:0] p);
      int c = 0;
      @(negedge clk);
      pat            = p;
      bus.chal_data  = d;
      bus.chal_valid = 1'b1;
      while (!bus.chal_ready && c < 200) begin
         @(negedge clk);
         c++;
      end
      if (c >= 200) chk("chal_ready_timeout", 32'(bus.chal_ready), 32'(1));
      @(negedge clk);
      bus.chal_valid = 1'b0;
   endtask

   task automatic run_one(input logic [ST-1:0] d, input logic [RP-1:0] p, input int hold,
                          output int lat, output int pulses, output logic [ST-1:0] chal_seen,
                          output int ones, output logic rbit, output logic stable);
      int base;
      offer(d, p);
      chal_seen = puf_chal;
      base      = n_pulse;
      lat       = 0;
      while (!bus.resp_valid && lat < 400) begin
         @(negedge clk);
         lat++;
      end
      pulses = n_pulse - base;
      ones   = int'(bus.resp_ones);
      rbit   = bus.resp_bit;
      stable = bus.resp_stable;
      repeat (hold) @(negedge clk);
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
   endtask

   task automatic wait_ack();
      int c = 0;
      while (!bus.resp_valid && c < 400) begin
         @(negedge clk);
         c++;
      end
      chk("resp_wait", 32'(bus.resp_valid), 32'(1));
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int            lat, pulses, ones, c, n;
      logic [ST-1:0] cs;
      logic          rb, stb;
      bus.chal_valid  = 1'b0;
      bus.chal_data   = '0;
      bus.resp_ready  = 1'b0;
      bus1.chal_valid = 1'b0;
      bus1.chal_data  = '0;
      bus1.resp_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_chal_ready", 32'(bus.chal_ready), 32'(1));
      chk("reset_launch", 32'(puf_launch), 32'(0));
      chk("reset_busy", 32'(busy), 32'(0));
      chk("reset_resp_valid", 32'(bus.resp_valid), 32'(0));
      chk("reset_resp_ones", 32'(bus.resp_ones), 32'(0));
      chk("reset_puf_chal", 32'(puf_chal), 32'(0));
      rstn = 1'b1;
      repeat (2) @(negedge clk);

      // Arbiter always 1; also counts launch pulses per challenge
      run_one(8'hA5, 5'b11111, 0, lat, pulses, cs, ones, rb, stb);
      chk("t1_chal", 32'(cs), 32'(8'hA5));
      chk("t1_latency", 32'(lat), 32'(49));
      chk("t1_ones", 32'(ones), 32'(5));
      chk("t1_bit", 32'(rb), 32'(1));
      chk("t1_stable", 32'(stb), 32'(1));
      chk("t5_pulses", 32'(pulses), 32'(5));

      // Races 1,0,1,0,1 then 0,0,1,0,1 (bit i = race i+1)
      run_one(8'h11, 5'b10101, 1, lat, pulses, cs, ones, rb, stb);
      chk("t2a_ones", 32'(ones), 32'(3));
      chk("t2a_bit", 32'(rb), 32'(1));
      chk("t2a_stable", 32'(stb), 32'(0));
      run_one(8'h22, 5'b10100, 2, lat, pulses, cs, ones, rb, stb);
      chk("t2b_ones", 32'(ones), 32'(2));
      chk("t2b_bit", 32'(rb), 32'(0));
      chk("t2b_stable", 32'(stb), 32'(0));
      run_one(8'h00, 5'b00000, 0, lat, pulses, cs, ones, rb, stb);
      chk("t2c_ones", 32'(ones), 32'(0));
      chk("t2c_stable", 32'(stb), 32'(1));

      // Held response with a pending challenge
      offer(8'h5A, 5'($urandom));
      c = 0;
      while (!bus.resp_valid && c < 400) begin
         @(negedge clk);
         c++;
      end
      pat            = 5'($urandom);
      bus.chal_data  = 8'h3C;
      bus.chal_valid = 1'b1;
      repeat (20) @(negedge clk);
      chk("t3_hold_valid", 32'(bus.resp_valid), 32'(1));
      chk("t3_hold_ready", 32'(bus.chal_ready), 32'(0));
      chk("t3_hold_chal", 32'(puf_chal), 32'(8'h5A));
      bus.resp_ready = 1'b1;
      @(negedge clk);
      bus.resp_ready = 1'b0;
      chk("t3_bubble_ready", 32'(bus.chal_ready), 32'(1));
      chk("t3_bubble_chal", 32'(puf_chal), 32'(8'h5A));
      @(negedge clk);
      bus.chal_valid = 1'b0;
      chk("t3_accept_chal", 32'(puf_chal), 32'(8'h3C));
      chk("t3_accept_busy", 32'(busy), 32'(1));
      wait_ack();

      // Reset during the third LAUNCH
      offer(8'hC3, 5'b01011);
      n = n_pulse;
      c = 0;
      while ((n_pulse - n) < 3 && c < 200) begin
         @(negedge clk);
         c++;
      end
      chk("t4_third_pulse", 32'(n_pulse - n), 32'(3));
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      chk("t4_launch", 32'(puf_launch), 32'(0));
      chk("t4_busy", 32'(busy), 32'(0));
      chk("t4_chal_ready", 32'(bus.chal_ready), 32'(1));
      chk("t4_puf_chal", 32'(puf_chal), 32'(0));
      rstn = 1'b1;
      n = 0;
      repeat (80) begin
         @(negedge clk);
         if (bus.resp_valid) n++;
      end
      chk("t4_no_resp", 32'(n), 32'(0));

      // Randomized traffic, checked per cycle by the model
      for (int i = 0; i < 12; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         run_one(8'($urandom), 5'($urandom), $urandom_range(0, 3), lat, pulses, cs, ones, rb, stb);
         chk("rnd_latency", 32'(lat), 32'(LAT));
      end

      // REPS=1 instance against a free-running arbiter
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         bus1.chal_data  = 8'($urandom);
         bus1.chal_valid = 1'b1;
         c = 0;
         while (!bus1.chal_ready && c < 100) begin
            @(negedge clk);
            c++;
         end
         @(negedge clk);
         bus1.chal_valid = 1'b0;
         c = 0;
         while (!bus1.resp_valid && c < 100) begin
            @(negedge clk);
            c++;
         end
         chk("t6_latency", 32'(c), 32'(LAT1));
         chk("t6_stable", 32'(bus1.resp_stable), 32'(1));
         chk("t6_bit_vs_ones", 32'(bus1.resp_bit), 32'(bus1.resp_ones));
         bus1.resp_ready = 1'b1;
         @(negedge clk);
         bus1.resp_ready = 1'b0;
         n = 0;
         repeat (20) begin
            @(negedge clk);
            if (bus1.resp_valid) n++;
         end
         chk("t6_single_resp", 32'(n), 32'(0));
      end

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
